// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : vga_timing_ctrl                                               |
// | Purpose  : VGA raster sequencer. Owns the pixel/line counters, the       |
// |            pixel-enable cadence and the registered HSYNC/VSYNC/DE decode.|
// |            Run/stop is applied at frame granularity so a frame is never  |
// |            torn.                                                         |
// | Ports    : CLK          system clock                                     |
// |            RST          asynchronous active-high reset                   |
// |            EN           run request (level)                              |
// |            CE           pixel enable, one pulse per pixel                |
// |            X, Y         raster position of the presented pixel           |
// |            HSYNC/VSYNC  sync pulses, polarity set by SYNC_POL            |
// |            DE           visible-area flag                                |
// |            LINE_START   one-pixel pulse with X = 0                       |
// |            FRAME_START  one-pixel pulse with X = 0, Y = 0                |
// |            RUNNING      high while in RUN or DRAIN                       |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module vga_timing_ctrl #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter int unsigned CE_DIV   = 1,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        EN,
  output logic        CE,
  output logic [10:0] X,
  output logic [9:0]  Y,
  output logic        HSYNC,
  output logic        VSYNC,
  output logic        DE,
  output logic        LINE_START,
  output logic        FRAME_START,
  output logic        RUNNING
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
  localparam logic [9:0]  V_LAST     = 10'(V_TOTAL - 1);
  // Decode bounds carry one extra bit so an end value equal to 2048/1024
  // (sync or active region touching the top of the range) still compares.
  localparam logic [11:0] H_DE_END   = 12'(H_ACTIVE);
  localparam logic [11:0] HS_START   = 12'(H_ACTIVE + H_FP);
  localparam logic [11:0] HS_END     = 12'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] V_DE_END   = 11'(V_ACTIVE);
  localparam logic [10:0] VS_START   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END     = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [3:0]  PRESC_LAST = 4'(CE_DIV - 1);
  localparam logic        SYNC_IDLE  = ~SYNC_POL;

  generate
    if ((H_TOTAL > 2048) || (V_TOTAL > 1024) || (H_TOTAL < 1) || (V_TOTAL < 1) ||
        (CE_DIV < 1) || (CE_DIV > 16)) begin : g_param_check
      $error("vga_timing_ctrl: illegal timing parameters");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  presc_q, presc_d;
  logic [10:0] x_q, x_d;
  logic [9:0]  y_q, y_d;
  logic        ce_q, ce_d;
  logic        hsync_q, hsync_d;
  logic        vsync_q, vsync_d;
  logic        de_q, de_d;
  logic        line_start_q, line_start_d;
  logic        frame_start_q, frame_start_d;

  logic        tick;
  logic        load;
  logic        live;
  logic        at_last_x;
  logic        at_last_px;
  logic [11:0] x_ext;
  logic [10:0] y_ext;

  always_comb begin
    state_d    = state_q;
    presc_d    = presc_q;
    x_d        = x_q;
    y_d        = y_q;
    tick       = 1'b0;
    load       = 1'b0;
    at_last_x  = (x_q == H_LAST);
    at_last_px = at_last_x && (y_q == V_LAST);

    case (state_q)
      S_IDLE: begin
        presc_d = 4'd0;
        x_d     = 11'd0;
        y_d     = 10'd0;
        if (EN) begin
          // The start edge itself presents pixel (0,0) with FRAME_START.
          state_d = S_RUN;
          load    = 1'b1;
        end
      end
      default: begin
        tick    = (presc_q == PRESC_LAST);
        presc_d = tick ? 4'd0 : presc_q + 4'd1;
        load    = tick;
        if (tick) begin
          if (at_last_x) begin
            x_d = 11'd0;
            y_d = at_last_px ? 10'd0 : y_q + 10'd1;
          end else begin
            x_d = x_q + 11'd1;
          end
        end
        // EN wins over the end-of-frame exit; a RUN that loses EN on its
        // final pixel only enters DRAIN, so one more full frame is drawn.
        if (EN) begin
          state_d = S_RUN;
        end else if ((state_q == S_DRAIN) && tick && at_last_px) begin
          state_d = S_IDLE;
          presc_d = 4'd0;
        end else begin
          state_d = S_DRAIN;
        end
      end
    endcase

    // Decode from next-state counters so the registered flags line up with
    // the registered X/Y they describe.
    live          = (state_d != S_IDLE);
    x_ext         = {1'b0, x_d};
    y_ext         = {1'b0, y_d};
    ce_d          = live && load;
    de_d          = live && (x_ext < H_DE_END) && (y_ext < V_DE_END);
    hsync_d       = (live && (x_ext >= HS_START) && (x_ext < HS_END)) ? SYNC_POL : SYNC_IDLE;
    vsync_d       = (live && (y_ext >= VS_START) && (y_ext < VS_END)) ? SYNC_POL : SYNC_IDLE;
    line_start_d  = ce_d && (x_d == 11'd0);
    frame_start_d = line_start_d && (y_d == 10'd0);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q       <= S_IDLE;
      presc_q       <= 4'd0;
      x_q           <= 11'd0;
      y_q           <= 10'd0;
      ce_q          <= 1'b0;
      hsync_q       <= SYNC_IDLE;
      vsync_q       <= SYNC_IDLE;
      de_q          <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      presc_q       <= presc_d;
      x_q           <= x_d;
      y_q           <= y_d;
      ce_q          <= ce_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      de_q          <= de_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign CE          = ce_q;
  assign X           = x_q;
  assign Y           = y_q;
  assign HSYNC       = hsync_q;
  assign VSYNC       = vsync_q;
  assign DE          = de_q;
  assign LINE_START  = line_start_q;
  assign FRAME_START = frame_start_q;
  assign RUNNING     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_vga_timing_ctrl                                            |
// | Purpose  : Self-checking bench for vga_timing_ctrl. Instance A uses the  |
// |            800x600 timing with CE_DIV = 1; instance B uses a reduced     |
// |            32x20 raster with CE_DIV = 2 and active-low syncs so whole    |
// |            frames fit in a short run.                                    |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_vga_timing_ctrl;

  typedef struct packed {
    int ha; int hfp; int hs; int hbp;
    int va; int vfp; int vs; int vbp;
    int div; bit pol;
  } cfg_t;

  typedef struct packed {
    int st;   // 0 idle, 1 run, 2 drain
    int idx;  // linear pixel index within the frame
    int ph;   // clocks since the last pixel step
    bit load; // a pixel was presented on this edge
  } mdl_t;

  typedef struct packed {
    logic        ce;
    logic [10:0] x;
    logic [9:0]  y;
    logic        hs, vs, de, ls, fs, run;
  } obs_t;

  localparam cfg_t CFG_A = '{ha:800, hfp:56, hs:120, hbp:64, va:600, vfp:37, vs:6, vbp:23, div:1, pol:1'b1};
  localparam cfg_t CFG_B = '{ha:16,  hfp:4,  hs:6,   hbp:6,  va:12,  vfp:2,  vs:3, vbp:3,  div:2, pol:1'b0};

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic en_a = 1'b0;
  logic en_b = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  logic        ce_a, hs_a, vs_a, de_a, ls_a, fs_a, run_a;
  logic [10:0] x_a;
  logic [9:0]  y_a;
  logic        ce_b, hs_b, vs_b, de_b, ls_b, fs_b, run_b;
  logic [10:0] x_b;
  logic [9:0]  y_b;

  vga_timing_ctrl u_dut_a (
    .CLK(clk), .RST(rst), .EN(en_a), .CE(ce_a), .X(x_a), .Y(y_a),
    .HSYNC(hs_a), .VSYNC(vs_a), .DE(de_a), .LINE_START(ls_a),
    .FRAME_START(fs_a), .RUNNING(run_a)
  );

  vga_timing_ctrl #(
    .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(6),
    .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(3),
    .CE_DIV(2), .SYNC_POL(1'b0)
  ) u_dut_b (
    .CLK(clk), .RST(rst), .EN(en_b), .CE(ce_b), .X(x_b), .Y(y_b),
    .HSYNC(hs_b), .VSYNC(vs_b), .DE(de_b), .LINE_START(ls_b),
    .FRAME_START(fs_b), .RUNNING(run_b)
  );

  obs_t obs_a, obs_b, exp_a, exp_b;
  assign obs_a = {ce_a, x_a, y_a, hs_a, vs_a, de_a, ls_a, fs_a, run_a};
  assign obs_b = {ce_b, x_b, y_b, hs_b, vs_b, de_b, ls_b, fs_b, run_b};

  // Reference behaviour: one clock edge of the raster sequencer.
  function automatic mdl_t mdl_step(cfg_t c, mdl_t m, bit en);
    mdl_t n = m;
    int   npx = (c.ha + c.hfp + c.hs + c.hbp) * (c.va + c.vfp + c.vs + c.vbp);
    bit   tick;
    bit   last;
    n.load = 1'b0;
    if (m.st == 0) begin
      if (en) begin
        n.st = 1; n.idx = 0; n.ph = 0; n.load = 1'b1;
      end
    end else begin
      tick   = (m.ph == c.div - 1);
      last   = (m.idx == npx - 1);
      n.ph   = tick ? 0 : m.ph + 1;
      n.load = tick;
      if (tick) n.idx = last ? 0 : m.idx + 1;
      if (en) n.st = 1;
      else if (m.st == 2 && tick && last) begin
        n.st = 0; n.ph = 0; n.load = 1'b0;
      end else n.st = 2;
    end
    return n;
  endfunction

  function automatic obs_t mdl_out(cfg_t c, mdl_t m);
    obs_t o;
    int   ht   = c.ha + c.hfp + c.hs + c.hbp;
    int   x    = m.idx % ht;
    int   y    = m.idx / ht;
    bit   live = (m.st != 0);
    o.x   = 11'(x);
    o.y   = 10'(y);
    o.run = live;
    o.ce  = live && m.load;
    o.de  = live && (x < c.ha) && (y < c.va);
    o.hs  = (live && x >= c.ha + c.hfp && x < c.ha + c.hfp + c.hs) ? c.pol : ~c.pol;
    o.vs  = (live && y >= c.va + c.vfp && y < c.va + c.vfp + c.vs) ? c.pol : ~c.pol;
    o.ls  = o.ce && (x == 0);
    o.fs  = o.ce && (m.idx == 0);
    return o;
  endfunction

  // Scoreboard producers: push the expected outputs for every clock/reset.
  mdl_t m_a = '0;
  mdl_t m_b = '0;
  obs_t sb_a[$];
  obs_t sb_b[$];

  initial forever begin
    @(posedge clk or posedge rst);
    if (rst) begin
      m_a = '0; m_b = '0;
      sb_a.delete(); sb_b.delete();
    end else begin
      m_a = mdl_step(CFG_A, m_a, en_a);
      m_b = mdl_step(CFG_B, m_b, en_b);
    end
    sb_a.push_back(mdl_out(CFG_A, m_a));
    sb_b.push_back(mdl_out(CFG_B, m_b));
  end

  // Scoreboard consumers: compare on the falling edge, away from updates.
  initial forever begin
    @(negedge clk);
    vectors++;
    if (sb_a.size() == 0) begin
      miscompares++;
      $display("FAIL sb_a t=%0t: no expected entry, got %h", $time, obs_a);
    end else begin
      exp_a = sb_a.pop_front();
      if (obs_a !== exp_a) begin
        miscompares++;
        $display("FAIL sb_a t=%0t: got ce=%b x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b run=%b, expected ce=%b x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b run=%b",
                 $time, obs_a.ce, obs_a.x, obs_a.y, obs_a.hs, obs_a.vs, obs_a.de, obs_a.ls, obs_a.fs, obs_a.run,
                 exp_a.ce, exp_a.x, exp_a.y, exp_a.hs, exp_a.vs, exp_a.de, exp_a.ls, exp_a.fs, exp_a.run);
      end
    end
    vectors++;
    if (sb_b.size() == 0) begin
      miscompares++;
      $display("FAIL sb_b t=%0t: no expected entry, got %h", $time, obs_b);
    end else begin
      exp_b = sb_b.pop_front();
      if (obs_b !== exp_b) begin
        miscompares++;
        $display("FAIL sb_b t=%0t: got ce=%b x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b run=%b, expected ce=%b x=%0d y=%0d hs=%b vs=%b de=%b ls=%b fs=%b run=%b",
                 $time, obs_b.ce, obs_b.x, obs_b.y, obs_b.hs, obs_b.vs, obs_b.de, obs_b.ls, obs_b.fs, obs_b.run,
                 exp_b.ce, exp_b.x, exp_b.y, exp_b.hs, exp_b.vs, exp_b.de, exp_b.ls, exp_b.fs, exp_b.run);
      end
    end
  end

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({ce_a, de_a, ls_a, fs_a, run_a, hs_a, vs_a} !== 7'b0) begin
      miscompares++;
      $display("FAIL reset_flags_a: got %b expected 0000000", {ce_a, de_a, ls_a, fs_a, run_a, hs_a, vs_a});
    end
    vectors++;
    if ({x_a, y_a} !== 21'd0) begin
      miscompares++;
      $display("FAIL reset_xy_a: got x=%0d y=%0d expected 0,0", x_a, y_a);
    end
    vectors++;
    if ({hs_b, vs_b, run_b, ce_b} !== 4'b1100) begin
      miscompares++;
      $display("FAIL reset_b: got hs,vs,run,ce=%b expected 1100", {hs_b, vs_b, run_b, ce_b});
    end
    rst = 1'b0;
  endtask

  task automatic test_start();
    int n;
    @(negedge clk);
    en_a = 1'b1;
    @(negedge clk);
    vectors++;
    if ({fs_a, ls_a, ce_a, de_a, run_a} !== 5'b11111 || {x_a, y_a} !== 21'd0) begin
      miscompares++;
      $display("FAIL start_first_pixel: got fs,ls,ce,de,run=%b x=%0d y=%0d expected 11111 0,0",
               {fs_a, ls_a, ce_a, de_a, run_a}, x_a, y_a);
    end
    n = 0;
    while (x_a !== 11'd799 && n < 1000) begin @(negedge clk); n++; end
    vectors++;
    if (x_a !== 11'd799 || de_a !== 1'b1) begin
      miscompares++;
      $display("FAIL last_active: got x=%0d de=%b expected 799 1", x_a, de_a);
    end
    @(negedge clk);
    vectors++;
    if (x_a !== 11'd800 || de_a !== 1'b0) begin
      miscompares++;
      $display("FAIL first_blank: got x=%0d de=%b expected 800 0", x_a, de_a);
    end
  endtask

  task automatic test_hsync_line();
    int n, period, hs_cnt, first, last;
    n = 0;
    while (ls_a !== 1'b1 && n < 2100) begin @(negedge clk); n++; end
    vectors++;
    if (ls_a !== 1'b1 || x_a !== 11'd0) begin
      miscompares++;
      $display("FAIL line_start_seen: got ls=%b x=%0d expected 1 0", ls_a, x_a);
    end
    period = 0; hs_cnt = 0; first = -1; last = -1;
    do begin
      @(negedge clk);
      period++;
      if (hs_a === 1'b1) begin
        hs_cnt++;
        if (first < 0) first = int'(x_a);
        last = int'(x_a);
      end
    end while (ls_a !== 1'b1 && period < 2100);
    vectors++;
    if (period !== 1040) begin
      miscompares++;
      $display("FAIL line_period: got %0d expected 1040", period);
    end
    vectors++;
    if (hs_cnt !== 120 || first !== 856 || last !== 975) begin
      miscompares++;
      $display("FAIL hsync_window: got count=%0d first=%0d last=%0d expected 120 856 975", hs_cnt, first, last);
    end
  endtask

  task automatic test_async_reset();
    int n;
    n = 0;
    while (!(x_a === 11'd500 && y_a === 10'd10) && n < 12000) begin @(negedge clk); n++; end
    vectors++;
    if (x_a !== 11'd500 || y_a !== 10'd10) begin
      miscompares++;
      $display("FAIL reach_500_10: got x=%0d y=%0d expected 500 10", x_a, y_a);
    end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({x_a, y_a} !== 21'd0 || {ce_a, de_a, ls_a, fs_a, run_a, hs_a, vs_a} !== 7'b0) begin
      miscompares++;
      $display("FAIL async_reset: got x=%0d y=%0d flags=%b expected 0 0 0000000",
               x_a, y_a, {ce_a, de_a, ls_a, fs_a, run_a, hs_a, vs_a});
    end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if ({fs_a, run_a} !== 2'b11 || {x_a, y_a} !== 21'd0) begin
      miscompares++;
      $display("FAIL restart_after_reset: got fs,run=%b x=%0d y=%0d expected 11 0 0", {fs_a, run_a}, x_a, y_a);
    end
    en_a = 1'b0;
  endtask

  task automatic test_ce_div();
    int n, period;
    @(negedge clk);
    en_b = 1'b1;
    @(negedge clk);
    vectors++;
    if ({fs_b, ce_b} !== 2'b11 || {x_b, y_b} !== 21'd0) begin
      miscompares++;
      $display("FAIL b_start: got fs,ce=%b x=%0d y=%0d expected 11 0 0", {fs_b, ce_b}, x_b, y_b);
    end
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      vectors++;
      if (ce_b !== ((k % 2) == 0) || x_b !== 11'(k / 2)) begin
        miscompares++;
        $display("FAIL ce_cadence[%0d]: got ce=%b x=%0d expected %b %0d", k, ce_b, x_b, ((k % 2) == 0), k / 2);
      end
    end
    n = 0;
    while (ls_b !== 1'b1 && n < 200) begin @(negedge clk); n++; end
    period = 0;
    do begin @(negedge clk); period++; end while (ls_b !== 1'b1 && period < 200);
    vectors++;
    if (period !== 64) begin
      miscompares++;
      $display("FAIL b_line_period: got %0d expected 64", period);
    end
  endtask

  task automatic test_frame();
    int n, period, vs_cnt, ymin, ymax, px, py;
    n = 0;
    while (fs_b !== 1'b1 && n < 1400) begin @(negedge clk); n++; end
    period = 0; vs_cnt = 0; ymin = 9999; ymax = -1; px = -1; py = -1;
    do begin
      px = int'(x_b); py = int'(y_b);
      @(negedge clk);
      period++;
      if (vs_b === 1'b0) begin
        vs_cnt++;
        if (int'(y_b) < ymin) ymin = int'(y_b);
        if (int'(y_b) > ymax) ymax = int'(y_b);
      end
    end while (fs_b !== 1'b1 && period < 1400);
    vectors++;
    if (period !== 1280) begin
      miscompares++;
      $display("FAIL frame_period: got %0d expected 1280", period);
    end
    vectors++;
    if (vs_cnt !== 192 || ymin !== 14 || ymax !== 16) begin
      miscompares++;
      $display("FAIL vsync_window: got count=%0d ymin=%0d ymax=%0d expected 192 14 16", vs_cnt, ymin, ymax);
    end
    vectors++;
    if (px !== 31 || py !== 19 || {x_b, y_b} !== 21'd0) begin
      miscompares++;
      $display("FAIL frame_wrap: got prev=(%0d,%0d) now=(%0d,%0d) expected (31,19) (0,0)", px, py, x_b, y_b);
    end
  endtask

  task automatic test_drain();
    int n, cycles, fs_seen, lx, ly;
    n = 0;
    while (y_b !== 10'd6 && n < 1400) begin @(negedge clk); n++; end
    en_b = 1'b0;
    cycles = 0; fs_seen = 0; lx = -1; ly = -1;
    while (run_b === 1'b1 && cycles < 1400) begin
      lx = int'(x_b); ly = int'(y_b);
      @(negedge clk);
      cycles++;
      if (fs_b === 1'b1) fs_seen++;
    end
    vectors++;
    if (run_b !== 1'b0 || lx !== 31 || ly !== 19 || fs_seen !== 0) begin
      miscompares++;
      $display("FAIL drain_end: got run=%b last=(%0d,%0d) fs=%0d expected 0 (31,19) 0", run_b, lx, ly, fs_seen);
    end
    vectors++;
    if ({x_b, y_b} !== 21'd0 || {hs_b, vs_b, de_b, ce_b} !== 4'b1100) begin
      miscompares++;
      $display("FAIL drain_idle: got x=%0d y=%0d hs,vs,de,ce=%b expected 0 0 1100", x_b, y_b, {hs_b, vs_b, de_b, ce_b});
    end
    fs_seen = 0;
    repeat (100) begin @(negedge clk); if (fs_b === 1'b1 || run_b === 1'b1) fs_seen++; end
    vectors++;
    if (fs_seen !== 0) begin
      miscompares++;
      $display("FAIL idle_quiet: got %0d active cycles expected 0", fs_seen);
    end
  endtask

  task automatic test_drain_resume();
    int n, ces, sidx, eidx;
    en_b = 1'b1;
    n = 0;
    while (y_b !== 10'd4 && n < 1400) begin @(negedge clk); n++; end
    en_b = 1'b0;
    ces  = 0;
    sidx = int'(y_b) * 32 + int'(x_b);
    repeat (10) begin @(negedge clk); if (ce_b === 1'b1) ces++; end
    vectors++;
    if (run_b !== 1'b1) begin
      miscompares++;
      $display("FAIL drain_running: got run=%b expected 1", run_b);
    end
    en_b = 1'b1;
    repeat (10) begin @(negedge clk); if (ce_b === 1'b1) ces++; end
    eidx = int'(y_b) * 32 + int'(x_b);
    vectors++;
    if (eidx - sidx !== ces || ces !== 10) begin
      miscompares++;
      $display("FAIL resume_continuity: got advance=%0d ce=%0d expected 10 10", eidx - sidx, ces);
    end
    n = 0;
    while (fs_b !== 1'b1 && n < 1400) begin @(negedge clk); n++; end
    vectors++;
    if (fs_b !== 1'b1 || run_b !== 1'b1) begin
      miscompares++;
      $display("FAIL resume_next_frame: got fs=%b run=%b expected 1 1", fs_b, run_b);
    end
  endtask

  task automatic test_simultaneous();
    int n, cycles, fs_seen;
    n = 0;
    while (!(x_b === 11'd31 && y_b === 10'd19 && ce_b === 1'b0) && n < 1400) begin @(negedge clk); n++; end
    en_b = 1'b0;
    @(negedge clk);
    vectors++;
    if ({fs_b, run_b} !== 2'b11 || {x_b, y_b} !== 21'd0) begin
      miscompares++;
      $display("FAIL simul_wrap: got fs,run=%b x=%0d y=%0d expected 11 0 0", {fs_b, run_b}, x_b, y_b);
    end
    cycles = 0; fs_seen = 0;
    while (run_b === 1'b1 && cycles < 3000) begin
      @(negedge clk);
      cycles++;
      if (fs_b === 1'b1) fs_seen++;
    end
    vectors++;
    if (cycles !== 1280 || fs_seen !== 0) begin
      miscompares++;
      $display("FAIL simul_extra_frame: got cycles=%0d fs=%0d expected 1280 0", cycles, fs_seen);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_hsync_line();
    test_async_reset();
    test_ce_div();
    test_frame();
    test_drain();
    test_drain_resume();
    test_simultaneous();
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
